// File: rtl/serial_pkg.sv
// Shared types and defaults for the serial transmit/receive blocks.
package serial_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/piso_serializer_if.sv
// Load handshake and serial output bundle for piso_serializer.
// master = the side that supplies words, slave = the serializer itself.
interface piso_serializer_if import serial_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
);
    logic [WIDTH-1:0] Pin;
    logic             load_valid;
    logic             load_ready;
    logic             Sout;
    logic             Sout_valid;
    logic             busy;
    logic             done;

    modport master (
        output Pin, load_valid,
        input  load_ready, Sout, Sout_valid, busy, done
    );

    modport slave (
        input  Pin, load_valid,
        output load_ready, Sout, Sout_valid, busy, done
    );
endinterface

// File: rtl/piso_serializer_bit_counter.sv
// Frame bit index counter: counts 0..WIDTH-1 and saturates at the terminal
// count, so the index can never run past the last bit of a frame.
module bit_counter import serial_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic Clock,
    input  logic reset,
    input  logic clear_i,
    input  logic en_i,
    output logic tc_o
);
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tc_o = (cnt_q == LAST);

    // Next index: clear wins over enable; hold once the last bit is reached.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Index register, cleared asynchronously.
    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter. A word accepted through the
// valid/ready handshake is shifted out LSB first, one bit per clock.
// A new word may be accepted during the last bit of a frame, which keeps
// back-to-back frames gap-free.
module piso_serializer import serial_pkg::*; #(
    parameter int   WIDTH    = DEF_WIDTH,
    parameter logic IDLE_LVL = 1'b0
) (
    input  logic              Clock,
    input  logic              reset,
    piso_serializer_if.slave  bus
);
    ser_state_t       state_q;
    logic [WIDTH-1:0] shreg_q;
    logic             last_bit;
    logic             shifting;
    logic             accept;

    assign shifting = (state_q == SHIFT);

    // Ready depends on registered state only, never on load_valid.
    assign bus.load_ready = !shifting || last_bit;
    assign accept         = bus.load_valid && bus.load_ready;

    // Outputs decode straight from registers.
    assign bus.Sout       = shifting ? shreg_q[0] : IDLE_LVL;
    assign bus.Sout_valid = shifting;
    assign bus.busy       = shifting;
    assign bus.done       = shifting && last_bit;

    // Bit index of the bit currently on Sout; restarts on every load and
    // returns to zero when a frame ends without a follow-on word.
    bit_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .Clock   (Clock),
        .reset   (reset),
        .clear_i (accept || (shifting && last_bit)),
        .en_i    (shifting),
        .tc_o    (last_bit)
    );

    // FSM plus shift register: load on accept, otherwise shift while in a
    // frame and drop to IDLE after the last bit. Reset aborts any frame.
    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
        end else if (accept) begin
            state_q <= SHIFT;
            shreg_q <= bus.Pin;
        end else if (shifting) begin
            shreg_q <= shreg_q >> 1;
            if (last_bit) begin
                state_q <= IDLE;
            end
        end
    end
endmodule
